if_stage: RTL

//   Instruction-fetch stage of the pipelined CPU. Holds the PC and drives the word address

---
 rtl/pipeline_pkg.sv | 15 +
 rtl/if_id_reg.sv | 36 +++
 rtl/if_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: constants and the IF/ID bundle type shared by the pipeline stages
//   DEFAULT_NOP_INST  instruction word loaded into a pipeline register on reset or flush
//   DEFAULT_RESET_PC  default byte address fetched after reset
//   if_id_t           IF/ID bundle {valid, pc, inst, pc_plus4, misalign}
package pipeline_pkg;
   localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] pc_plus4;
      logic        misalign;
   } if_id_t;
endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load/hold/flush controls (priority rst > flush > load > hold)
//   clk, rst  clock and synchronous active-high reset
//   load      capture d into every field
//   flush     clear valid and replace inst with NOP_INST; pc, pc_plus4 and misalign hold
//   d, q      incoming and registered bundles
module if_id_reg
   import pipeline_pkg::*;
#(
   parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   flush,
   input  if_id_t d,
   output if_id_t q
);
   if_id_t r_d, r_q;

   always_comb begin
      r_d = r_q;
      if (flush) begin
         r_d.valid = 1'b0;
         r_d.inst  = NOP_INST;
      end else if (load) begin
         r_d = d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_q <= '{valid: 1'b0, pc: 32'h0, inst: NOP_INST, pc_plus4: 32'h0, misalign: 1'b0};
      else     r_q <= r_d;
   end

   assign q = r_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch stage; owns the PC, addresses the async ROM and fills IF/ID
//   clk, rst      clock and synchronous active-high reset
//   rom_addr      word address {2'b00, pc[31:2]} (combinational)
//   rom_data      instruction word returned by the ROM in the same cycle
//   stall         hold pc and IF/ID
//   redirect      load pc from redirect_pc and flush IF/ID (beats stall)
//   if_pc         current pc
//   id_*          IF/ID register fields
//   fetch_cnt, bubble_cnt  performance counters, present only when IF_PERF_CNT_EN is defined
module if_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] if_pc,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc_plus4,
   output logic        id_misalign
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] fetch_cnt,
   output logic [31:0] bubble_cnt
`endif
);
   logic [31:0] pc_d, pc_q;
   logic        load;
   if_id_t      cap, id;

   assign load = !redirect && !stall;

   always_comb begin
      pc_d = redirect ? redirect_pc : stall ? pc_q : pc_q + 32'd4;
   end

   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_PC;
      else     pc_q <= pc_d;
   end

   // A misaligned pc still fetches word pc[31:2]; the flag travels with the instruction.
   assign cap = '{valid: 1'b1, pc: pc_q, inst: rom_data, pc_plus4: pc_q + 32'd4, misalign: |pc_q[1:0]};

   if_id_reg #(.NOP_INST(NOP_INST)) u_if_id (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .flush(redirect),
      .d    (cap),
      .q    (id)
   );

   assign rom_addr    = {2'b00, pc_q[31:2]};
   assign if_pc       = pc_q;
   assign id_valid    = id.valid;
   assign id_pc       = id.pc;
   assign id_inst     = id.inst;
   assign id_pc_plus4 = id.pc_plus4;
   assign id_misalign = id.misalign;

`ifdef IF_PERF_CNT_EN
   logic [31:0] fetch_cnt_d, fetch_cnt_q, bubble_cnt_d, bubble_cnt_q;

   always_comb begin
      fetch_cnt_d  = load ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
      bubble_cnt_d = load ? bubble_cnt_q : bubble_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q  <= 32'h0;
         bubble_cnt_q <= 32'h0;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign fetch_cnt  = fetch_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif
endmodule
